// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding
// and counter sizing.
package divisor_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        SUB   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divisor_fd.sv
// Divider datapath: partial remainder, dividend/quotient shifter, divisor
// register, bit counter and the WIDTH+1-bit trial subtractor.
module divisor_fd #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             shift_en,
    input  logic             sub_wr,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero,
    output logic             rsign,
    output logic             zero
);
    import divisor_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             dz_q;
    logic [WIDTH:0]   diff;

    // Extra MSB of the trial difference is the borrow: set means R < B.
    assign diff  = r_q - {1'b0, b_q};
    assign rsign = diff[WIDTH];
    assign zero  = (cnt == '0);

    assign q        = q_q;
    assign r        = r_q[WIDTH-1:0];
    assign div_zero = dz_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q  <= '0;
            q_q  <= '0;
            b_q  <= '0;
            cnt  <= '0;
            dz_q <= 1'b0;
        end else if (ld) begin
            r_q  <= '0;
            q_q  <= a_in;
            b_q  <= b_in;
            cnt  <= CW'(WIDTH);
            dz_q <= (b_in == '0);
        end else if (shift_en) begin
            {r_q, q_q} <= {r_q[WIDTH-1:0], q_q, 1'b0};
            cnt        <= cnt - CW'(1);
        end else if (sub_wr) begin
            r_q    <= diff;
            q_q[0] <= 1'b1;
        end
    end

endmodule

// File: rtl/divisor.sv
// Sequential restoring divider top: control FSM driving the divisor_fd
// datapath, one quotient bit per SHIFT/SUB pair, start/done handshake.
module divisor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             done,
    output logic [WIDTH-1:0] Q_out,
    output logic [WIDTH-1:0] R_out,
    output logic             div_zero
);
    import divisor_pkg::*;

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | capture operands, clear R, arm counter
    // SHIFT | shift {R,Q} left one bit, count down
    // SUB   | trial subtract; keep result and set Q[0] if no borrow
    // DONE  | one-cycle done pulse, results stable

    state_t state;
    logic   ld;
    logic   shift_en;
    logic   sub_wr;
    logic   rsign;
    logic   zero;

    assign ld       = (state == LOAD);
    assign shift_en = (state == SHIFT);
    // A borrow means restore, which is simply not writing R.
    assign sub_wr   = (state == SUB) && !rsign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    done  <= 1'b0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    done  <= 1'b0;
                    state <= SUB;
                end
                SUB: begin
                    if (zero) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= SHIFT;
                        done  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    divisor_fd #(.WIDTH(WIDTH)) u_fd (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .shift_en (shift_en),
        .sub_wr   (sub_wr),
        .a_in     (A_in),
        .b_in     (B_in),
        .q        (Q_out),
        .r        (R_out),
        .div_zero (div_zero),
        .rsign    (rsign),
        .zero     (zero)
    );

endmodule

// File: tb/tb_divisor.sv
// Self-checking bench for divisor: directed cases plus random sweeps at
// WIDTH=4 and WIDTH=8 against an arithmetic quotient/remainder model.
module tb_divisor;

    logic       clk;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       done4, done8;
    logic [3:0] q4, r4;
    logic [7:0] q8, r8;
    logic       dz4, dz8;

    int unsigned n_chk;
    int unsigned n_pass;

    divisor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A_in(a4), .B_in(b4),
        .done(done4), .Q_out(q4), .R_out(r4), .div_zero(dz4)
    );

    divisor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A_in(a8), .B_in(b8),
        .done(done8), .Q_out(q8), .R_out(r8), .div_zero(dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One full operation on the selected instance; latency counted in edges
    // after the edge that samples start.
    task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b, input bit repulse);
        int         lat;
        int         exp_lat;
        logic [7:0] mask;
        logic [7:0] eq;
        logic [7:0] er;
        mask    = w8 ? 8'hff : 8'h0f;
        exp_lat = w8 ? 17 : 9;
        if (b == 8'd0) begin
            eq = mask;
            er = a & mask;
        end else begin
            eq = (a & mask) / (b & mask);
            er = (a & mask) % (b & mask);
        end

        @(negedge clk);
        if (w8) begin a8 = a; b8 = b; start8 = 1'b1; end
        else begin a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1; end
        @(posedge clk); #1;
        start4 = 1'b0;
        start8 = 1'b0;
        lat = 0;
        while (!(w8 ? done8 : done4) && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                a4 = 4'($urandom); b4 = 4'($urandom);
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            if (repulse && lat == 4) begin
                a4 = 4'd2; b4 = 4'd1; start4 = 1'b1;
                a8 = 8'd2; b8 = 8'd1; start8 = 1'b1;
            end
            if (repulse && lat == 5) begin
                start4 = 1'b0;
                start8 = 1'b0;
            end
        end
        check("latency", lat, exp_lat);
        check("quotient", w8 ? q8 : {4'd0, q4}, eq);
        check("remainder", w8 ? r8 : {4'd0, r4}, er);
        check("div_zero", w8 ? dz8 : dz4, (b == 8'd0) ? 1 : 0);
        @(posedge clk); #1;
        check("done_one_cycle", w8 ? done8 : done4, 0);
        check("result_hold", w8 ? q8 : {4'd0, q4}, eq);
    endtask

    initial begin
        int gap;
        bit saw_done;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        #1;
        check("rst_done", done4, 0);
        check("rst_q", q4, 0);
        check("rst_r", r4, 0);
        check("rst_dz", dz4, 0);
        check("rst_q8", q8, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(0, 8'd13, 8'd3, 0);
        run_op(0, 8'd15, 8'd1, 0);
        run_op(0, 8'd7,  8'd9, 0);
        run_op(0, 8'd9,  8'd9, 0);
        run_op(0, 8'd9,  8'd0, 0);
        repeat (3) @(posedge clk); #1;
        check("dz_holds", dz4, 1);
        run_op(0, 8'd6,  8'd4, 0);
        run_op(0, 8'd0,  8'd0, 0);
        run_op(0, 8'd15, 8'd15, 0);

        // Asynchronous reset in the middle of 13/3.
        @(negedge clk);
        a4 = 4'd13; b4 = 4'd3; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_q", q4, 0);
        check("midrst_r", r4, 0);
        check("midrst_done", done4, 0);
        check("midrst_dz", dz4, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done4) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done4) saw_done = 1'b1;
        end
        check("idle_after_rst", saw_done, 0);
        run_op(0, 8'd13, 8'd3, 0);

        run_op(0, 8'd13, 8'd3, 1);

        // start held high: done pulses every 2*WIDTH+3 cycles.
        @(negedge clk);
        a4 = 4'd11; b4 = 4'd2; start4 = 1'b1;
        gap = 0;
        while (!done4 && gap < 60) begin @(posedge clk); #1; gap++; end
        check("held_first_done", done4, 1);
        for (int k = 0; k < 2; k++) begin
            gap = 0;
            @(posedge clk); #1;
            gap++;
            while (!done4 && gap < 60) begin @(posedge clk); #1; gap++; end
            check("held_gap", gap, 11);
            check("held_q", q4, 5);
            check("held_r", r4, 1);
        end
        start4 = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (done4) saw_done = 1'b1;
        end
        check("held_release", saw_done, 0);

        run_op(1, 8'd200, 8'd7, 0);
        run_op(1, 8'd255, 8'd0, 0);
        run_op(1, 8'd255, 8'd255, 0);

        for (int i = 0; i < 40; i++)
            run_op(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 0);
        for (int i = 0; i < 25; i++)
            run_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/divisor.md
# divisor

Sequential restoring divider: unsigned WIDTH-bit dividend by WIDTH-bit divisor, producing quotient and remainder. One quotient bit per shift/subtract pair, under a small control FSM. Inverse companion of the shift-add multiplier in the arithmetic unit. Uses the same start/done handshake so the two blocks are interchangeable from a sequencer's point of view.

## Interface
- WIDTH, 4, operand width in bits; must be ≥ 2.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- start  input  1  request a division; sampled only in IDLE.
- done  output  1  one-cycle pulse; Q_out/R_out/div_zero are valid.
- A_in  input  WIDTH  dividend; captured in LOAD.
- B_in  input  WIDTH  divisor; captured in LOAD.
- Q_out  output  WIDTH  quotient register.
- R_out  output  WIDTH  remainder register.
- div_zero  output  1  divisor was 0 for the last operation.

## Operation
- Datapath registers:
  - R: WIDTH+1 bits, partial remainder, extra bit for the sign of the trial subtraction.
  - Q: WIDTH bits, dividend shifted in and quotient shifted out.
  - B: WIDTH bits.
  - cnt: ceil(log2(WIDTH+1)) bits.
- FSM states:
  - IDLE: start=1 → LOAD; otherwise stay.
  - LOAD: Q←A_in, B←B_in, R←0, cnt←WIDTH, div_zero←(B_in==0) → SHIFT.
  - SHIFT: {R,Q}←{R,Q}<<1 (Q[0]←0), cnt←cnt−1 → SUB.
  - SUB: compute D=R−{0,B} in WIDTH+1 bits.
    - D[WIDTH]==0 → R←D, Q[0]←1.
    - Otherwise R unchanged (restore), Q[0] stays 0.
    - Next state: cnt==0 → DONE; else → SHIFT.
  - DONE: done=1 (Moore output) → IDLE unconditionally.
- Q_out=Q and R_out=R[WIDTH-1:0] continuously. Both are intermediate during operation and stable from DONE until the next LOAD.
- Divide by zero:
  - No special path; the algorithm runs with full latency.
  - Result is the natural one: Q_out = all ones, R_out = A_in, div_zero=1.
  - div_zero holds until the next LOAD.
- start while not in IDLE: ignored. A_in/B_in changes outside LOAD: no effect.
- start held high through DONE: DONE→IDLE→LOAD, i.e. a back-to-back operation with a one-cycle IDLE gap.

## Timing
- Reset (rst=0, any state, any time):
  - state=IDLE.
  - R, Q, B, cnt, div_zero cleared, so done=0, Q_out=0, R_out=0, div_zero=0.
  - Takes effect immediately, without a clock edge.
  - Mid-operation reset aborts; partial results are discarded.
- Latency, counting from the edge that samples start=1 (edge 0):
  - LOAD executes at edge 1.
  - SHIFT/SUB pairs occupy edges 2 .. 2·WIDTH+1.
  - done is high for the cycle after edge 2·WIDTH+1. For WIDTH=4, done rises 9 edges after sampling and lasts exactly one cycle.
- Minimum start-to-start spacing: 2·WIDTH+3 cycles.
- Latency is fixed and data-independent, including when the divisor is 0.

## Structure
- Shared package/header divisor_pkg: state encoding localparams (IDLE, LOAD, SHIFT, SUB, DONE; 3-bit binary) and the cnt width function.
- Control FSM in the top module: state register, next-state logic, and enable/load decode for each register.
- One natural sub-module, divisor_fd: R/Q/B/cnt registers, WIDTH+1-bit subtractor, and status outputs rsign (D[WIDTH]) and zero (cnt==0).
- No other hierarchy.

## Test plan
- WIDTH=4, A=13, B=3, start pulsed 1 cycle → done pulses exactly 9 edges after sampling; Q_out=4, R_out=1, div_zero=0.
- A=15, B=1 → Q=15, R=0; then A=7, B=9 → Q=0, R=7; then A=9, B=9 → Q=1, R=0.
- A=9, B=0 → full latency, Q=15, R=9, div_zero=1. The next operation 6/4 → Q=1, R=2, div_zero=0.
- rst=0 asserted asynchronously mid-way through 13/3 → outputs 0 without a clock edge, state IDLE, no done. A new start then gives the correct result.
- start re-pulsed during SHIFT/SUB with different operands → ignored, original result delivered. start held high continuously → successive done pulses every 2·WIDTH+3 cycles.
- WIDTH=8, A=200, B=7 → Q=28, R=4, done 17 edges after sampling. Randomized sweep vs. A/B and A%B reference model.
